// File: rtl/hv_bundle.sv
// rtl/hv_bundle.sv - majority-vote bundler for binary hypervectors
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   start, n_vec, tie_hv job request; count and tie-break vector latched on accept
//   in_valid/in_ready    input vector handshake, in_hv is the vector
//   out_valid/out_ready  result handshake, out_hv is the bundled vector
//   busy                 high whenever a job is in progress
module hv_bundle #(
  parameter int D  = 64,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] n_vec,
  input  logic [D-1:0]  tie_hv,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [D-1:0]  in_hv,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [D-1:0]  out_hv,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    THRESH = 2'd2,
    OUT    = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [DW-1:0] cnt [D];
  logic [DW-1:0] vec_cnt;
  logic [DW-1:0] n_lat;
  logic [D-1:0]  tie_lat;
  logic [D-1:0]  thresh_hv;

  logic start_acc;
  logic accept;
  logic last_vec;

  assign start_acc = (state == IDLE) && start;
  assign accept    = in_valid && in_ready;
  // n_lat is never zero while in ACCUM, so vec_cnt+1 cannot wrap before matching.
  assign last_vec  = ((vec_cnt + DW'(1)) == n_lat);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_nxt = (n_vec != '0) ? ACCUM : THRESH;
        end
      end
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && last_vec) begin
          state_nxt = THRESH;
        end
      end
      THRESH: begin
        state_nxt = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Compare 2*cnt against n_vec in DW+1 bits so odd counts never round
  // and the doubled counter cannot overflow.
  always_comb begin
    thresh_hv = '0;
    for (int i = 0; i < D; i++) begin
      if ({cnt[i], 1'b0} > {1'b0, n_lat}) begin
        thresh_hv[i] = 1'b1;
      end else if ({cnt[i], 1'b0} == {1'b0, n_lat}) begin
        thresh_hv[i] = tie_lat[i];
      end else begin
        thresh_hv[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vec_cnt <= '0;
      n_lat   <= '0;
      tie_lat <= '0;
      out_hv  <= '0;
      for (int i = 0; i < D; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      if (start_acc) begin
        n_lat   <= n_vec;
        tie_lat <= tie_hv;
        vec_cnt <= '0;
        for (int i = 0; i < D; i++) begin
          cnt[i] <= '0;
        end
      end else if (accept) begin
        vec_cnt <= vec_cnt + DW'(1);
        for (int i = 0; i < D; i++) begin
          cnt[i] <= cnt[i] + DW'(in_hv[i]);
        end
      end
      // out_hv only changes here, so it stays put for the whole OUT state.
      if (state == THRESH) begin
        out_hv <= thresh_hv;
      end
    end
  end

endmodule

// File: tb/tb_hv_bundle.sv
// tb/tb_hv_bundle.sv - self-checking bench for hv_bundle (D=8, DW=4)
module tb_hv_bundle;

  localparam int D  = 8;
  localparam int DW = 4;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [DW-1:0] n_vec;
  logic [D-1:0]  tie_hv;
  logic          in_valid;
  logic          in_ready;
  logic [D-1:0]  in_hv;
  logic          out_valid;
  logic          out_ready;
  logic [D-1:0]  out_hv;
  logic          busy;

  int checks;
  int errors;

  hv_bundle #(.D(D), .DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .n_vec     (n_vec),
    .tie_hv    (tie_hv),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_hv     (in_hv),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_hv    (out_hv),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]        n;
    logic [7:0]        tie;
    logic [14:0][7:0]  vecs;
    logic [7:0]        exp;
  } vec_t;

  vec_t tbl [6];

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic run_job(input int n, input logic [7:0] tie, input logic [14:0][7:0] vecs,
                         input logic [7:0] exp, input bit gaps, input int bp,
                         input bit poke, input bit start_at_out);
    int budget;
    @(negedge clk);
    chk1("idle_busy", busy, 1'b0);
    chk1("idle_in_ready", in_ready, 1'b0);
    chk1("idle_out_valid", out_valid, 1'b0);
    start  = 1'b1;
    n_vec  = 4'(n);
    tie_hv = tie;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      start  = 1'b0;
      n_vec  = ~4'(n);
      tie_hv = ~tie;
      if (gaps) begin
        in_valid = 1'b0;
        in_hv    = 8'hFF;
        @(negedge clk);
        chk1("gap_in_ready", in_ready, 1'b1);
      end
      if (poke && k == 0) begin
        start = 1'b1;
        n_vec = 4'd1;
      end
      in_valid = 1'b1;
      in_hv    = vecs[k];
      budget   = 0;
      while (!in_ready && budget < 20) begin
        @(negedge clk);
        budget++;
      end
      if (!in_ready) begin
        chk1("in_ready_timeout", in_ready, 1'b1);
        in_valid = 1'b0;
        start    = 1'b0;
        return;
      end
    end
    // Last handshake (or the start itself when n=0) lands on the next edge.
    @(negedge clk);
    start    = 1'b0;
    n_vec    = ~4'(n);
    tie_hv   = ~tie;
    in_valid = 1'b1;
    in_hv    = 8'hFF;
    chk1("thresh_in_ready", in_ready, 1'b0);
    chk1("thresh_out_valid", out_valid, 1'b0);
    chk1("thresh_busy", busy, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    chk1("out_valid_lat2", out_valid, 1'b1);
    chk8("out_hv", out_hv, exp);
    for (int b = 0; b < bp; b++) begin
      out_ready = 1'b0;
      @(negedge clk);
      chk1("bp_out_valid", out_valid, 1'b1);
      chk8("bp_out_hv_hold", out_hv, exp);
    end
    out_ready = 1'b1;
    if (start_at_out) begin
      start = 1'b1;
      n_vec = 4'd2;
    end
    @(negedge clk);
    out_ready = 1'b0;
    start     = 1'b0;
    chk1("done_busy", busy, 1'b0);
    chk1("done_out_valid", out_valid, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    n_vec     = '0;
    tie_hv    = '0;
    in_valid  = 1'b0;
    in_hv     = '0;
    out_ready = 1'b0;

    tbl[0] = '{n: 4'd3, tie: 8'h00, vecs: '0, exp: 8'hE8};
    tbl[0].vecs[0] = 8'hF0; tbl[0].vecs[1] = 8'hCC; tbl[0].vecs[2] = 8'hAA;
    tbl[1] = '{n: 4'd2, tie: 8'h0F, vecs: '0, exp: 8'h0F};
    tbl[1].vecs[0] = 8'hFF; tbl[1].vecs[1] = 8'h00;
    tbl[2] = '{n: 4'd0, tie: 8'h5A, vecs: '0, exp: 8'h5A};
    tbl[3] = '{n: 4'd4, tie: 8'hA5, vecs: '0, exp: 8'h27};
    tbl[3].vecs[0] = 8'hFF; tbl[3].vecs[1] = 8'h0F; tbl[3].vecs[2] = 8'h33; tbl[3].vecs[3] = 8'h01;
    tbl[4] = '{n: 4'd15, tie: 8'h7E, vecs: '0, exp: 8'h81};
    for (int k = 0; k < 15; k++) tbl[4].vecs[k] = 8'h81;
    tbl[5] = '{n: 4'd1, tie: 8'hFF, vecs: '0, exp: 8'h3C};
    tbl[5].vecs[0] = 8'h3C;

    @(negedge clk);
    @(negedge clk);
    chk1("rst_in_ready", in_ready, 1'b0);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk8("rst_out_hv", out_hv, 8'h00);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_job(int'(tbl[i].n), tbl[i].tie, tbl[i].vecs, tbl[i].exp, 1'b0, i % 3, 1'b0, i == 1);
    end

    // Gaps on the input and five cycles of output backpressure.
    run_job(3, 8'h00, tbl[0].vecs, 8'hE8, 1'b1, 5, 1'b0, 1'b0);

    // A start pulse with a different count during ACCUM must be ignored.
    run_job(3, 8'h00, tbl[0].vecs, 8'hE8, 1'b0, 0, 1'b1, 1'b0);

    // Reset in ACCUM after one of three vectors aborts the job.
    @(negedge clk);
    start  = 1'b1;
    n_vec  = 4'd3;
    tie_hv = 8'h00;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b1;
    in_hv    = 8'hF0;
    chk1("abort_in_ready", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk1("abort_busy", busy, 1'b0);
    chk1("abort_out_valid", out_valid, 1'b0);
    chk1("abort_in_ready_low", in_ready, 1'b0);
    chk8("abort_out_hv", out_hv, 8'h00);
    run_job(1, 8'h00, tbl[5].vecs, 8'h3C, 1'b0, 0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
